ahb_single_master: RTL
======================

# ahb_single_master

Single-transfer AHB bus master that executes one request at a time from the processor-side memory adapter and drives the shared AMBA AHB bus. It sits directly downstream of the PicoRV32 memory adapter. It handles bus request/grant, address and data phases, wait states, and the ERROR/RETRY/SPLIT responses. Data lanes pass through unmodified; the upstream stage owns endianness and lane placement.

## Interface
- MAX_RETRY, 15: RETRY/SPLIT re-issues allowed per request; 0 = unlimited; exceeding it completes the request with error.
- clk  in  1  clock; all AHB signals are sampled and driven on its rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a transfer is accepted when req_valid && req_ready.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  32  byte address.
- req_size  in  3  HSIZE encoding; 0..2 legal.
- req_wdata  in  32  write data, lanes pre-placed.
- req_prot  in  4  HPROT value.
- req_lock  in  1  locked transfer.
- rsp_valid  out  1  one-cycle completion pulse; no backpressure.
- rsp_error  out  1  qualifies rsp_valid.
- rsp_rdata  out  32  read data, valid with rsp_valid for reads.
- hbusreq, hlock  out  1  arbitration request and lock.
- hgrant, hready  in  1  grant and bus ready.
- hresp  in  2  OKAY=0, ERROR=1, RETRY=2, SPLIT=3.
- hrdata  in  32  read data.
- htrans  out  2  IDLE=0, NONSEQ=2 only.
- haddr  out  32  address.
- hwrite  out  1  write select.
- hsize  out  3  transfer size.
- hburst  out  3  constant SINGLE (0).
- hprot  out  4  protection.
- hwdata  out  32  write data.

## Operation
- States: IDLE, ARB, ADDR, DATA, RESP2.
- IDLE: On accept, capture the request and check it:
  - req_size > 2, or haddr misaligned for its size (size 1 needs addr[0]=0; size 2 needs addr[1:0]=0): issue rsp_valid=1, rsp_error=1 next cycle, make no bus access, stay in IDLE.
  - Otherwise go to ARB and clear the retry counter.
- ARB: Drive hbusreq=1, hlock=req_lock, htrans=IDLE.
  - Sampling hgrant && hready high moves to ADDR.
- ADDR: Drive htrans=NONSEQ with haddr/hwrite/hsize/hprot from the captured request.
  - hready=1 moves to DATA. In the same edge: htrans<=IDLE, hwdata<=captured wdata, hbusreq<=0 (hlock held until DATA ends).
  - hready=0 holds all outputs.
- DATA:
  - hready=1, hresp=OKAY: capture hrdata, then rsp_valid=1, rsp_error=0; go to IDLE.
  - hready=0, hresp=OKAY: wait.
  - hready=0, hresp≠OKAY: go to RESP2 (first response cycle).
- RESP2:
  - ERROR with hready=1: rsp_valid=1, rsp_error=1; go to IDLE.
  - RETRY/SPLIT with hready=1: increment the retry counter.
    - If MAX_RETRY≠0 and the counter exceeds MAX_RETRY: error response; go to IDLE.
    - Otherwise go to ARB and re-issue the identical transfer.
- The retry counter is 8 bits and saturates; it compares as unsigned.

## Timing
- Reset values: req_ready=1; rsp_valid=0, rsp_error=0, rsp_rdata=0; hbusreq=0, hlock=0; htrans=IDLE; haddr=0, hwrite=0, hsize=0, hburst=0, hprot=0, hwdata=0. State=IDLE.
- All outputs are registered except req_ready, which decodes the state register.
- Zero-wait latency with a parked grant: accept at edge E0; hbusreq high in cycle 1; NONSEQ in cycle 2; data phase in cycle 3; rsp_valid in cycle 4.
- A new request may be accepted in the same cycle rsp_valid is high.
- Losing hgrant while in ADDR with hready=0: the address is still owned. The transfer completes normally per AHB rules.
- Reset asserted mid-transfer: the transfer is abandoned immediately and outputs return to reset values. No rsp_valid is issued.
- htrans is never NONSEQ during DATA or RESP2, so the bus is IDLE in the second cycle of a two-cycle response.

## Structure
- Shared header ahb_defs.vh holds the HTRANS, HRESP, HBURST and HSIZE constants and the state encodings; the adapter includes it too.
- Single module; no sub-module needed.

## Test plan
- Read 0x40000010 with hgrant parked, zero waits, hrdata=0xDEADBEEF -> rsp_valid at cycle 4 with rsp_rdata=0xDEADBEEF, rsp_error=0.
- Byte write to 0x20000003, wdata=0x000000A5, grant delayed 3 cycles, 2 data wait states -> hsize=0, hwdata=0x000000A5 in the data phase, one rsp_valid, hburst=0.
- ERROR two-cycle response on a write -> htrans=IDLE in both response cycles; rsp_valid with rsp_error=1.
- RETRY twice then OKAY, MAX_RETRY=15 -> three NONSEQ issues of identical addr/control; one OKAY rsp_valid.
- MAX_RETRY=1 with SPLIT on every attempt -> two bus attempts, then rsp_error=1.
- Halfword request at address 0x1001, and req_size=3 -> error rsp_valid next cycle, hbusreq never high. Separately, resetn pulse during DATA -> outputs at reset values, no rsp_valid.

Source files
------------

// File: rtl/ahb_single_master_pkg.sv
// Shared AHB constants, FSM state encoding and request legality check for the
// single-transfer AHB master.
package ahb_single_master_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARB,
    ST_ADDR,
    ST_DATA,
    ST_RESP2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  localparam logic [1:0] HRESP_OKAY  = 2'd0;
  localparam logic [1:0] HRESP_ERROR = 2'd1;
  localparam logic [1:0] HRESP_RETRY = 2'd2;
  localparam logic [1:0] HRESP_SPLIT = 2'd3;

  localparam logic [2:0] HBURST_SINGLE = 3'd0;

  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  // Sizes above a word, or addresses not aligned to the size, never reach the bus.
  function automatic logic req_illegal(input logic [2:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    if (size > HSIZE_WORD) begin
      bad = 1'b1;
    end else if (size == HSIZE_HALF && addr_lo[0]) begin
      bad = 1'b1;
    end else if (size == HSIZE_WORD && addr_lo != 2'b00) begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/ahb_single_master_if.sv
// Request/response handshake plus AHB master-side bus signals.
interface ahb_single_master_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_size;
  logic [31:0] req_wdata;
  logic [3:0]  req_prot;
  logic        req_lock;
  logic        rsp_valid;
  logic        rsp_error;
  logic [31:0] rsp_rdata;

  logic        hbusreq;
  logic        hlock;
  logic        hgrant;
  logic        hready;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic [3:0]  hprot;
  logic [31:0] hwdata;

  modport master (
    input  req_valid, req_write, req_addr, req_size, req_wdata, req_prot, req_lock,
    output req_ready, rsp_valid, rsp_error, rsp_rdata,
    input  hgrant, hready, hresp, hrdata,
    output hbusreq, hlock, htrans, haddr, hwrite, hsize, hburst, hprot, hwdata
  );

  modport slave (
    output req_valid, req_write, req_addr, req_size, req_wdata, req_prot, req_lock,
    input  req_ready, rsp_valid, rsp_error, rsp_rdata,
    output hgrant, hready, hresp, hrdata,
    input  hbusreq, hlock, htrans, haddr, hwrite, hsize, hburst, hprot, hwdata
  );

endinterface

// File: rtl/ahb_single_master.sv
// Single-transfer AHB master: one request at a time, with arbitration, wait
// states and ERROR/RETRY/SPLIT handling. All outputs except req_ready are registered.
module ahb_single_master
  import ahb_single_master_pkg::*;
#(
  parameter int MAX_RETRY = 15
) (
  input  logic                       clk,
  input  logic                       resetn,
  ahb_single_master_if.master        bus
);

  localparam logic [31:0] RETRY_LIMIT = 32'(MAX_RETRY);

  state_t      state, state_d;
  logic [7:0]  retry_cnt, retry_d, retry_inc;
  logic        retry_over;

  logic        cap_write, cap_lock;
  logic [31:0] cap_addr, cap_wdata;
  logic [2:0]  cap_size;
  logic [3:0]  cap_prot;

  logic        rsp_valid_q, rsp_valid_d, rsp_error_q, rsp_error_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        hbusreq_q, hbusreq_d, hlock_q, hlock_d, hwrite_q, hwrite_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic [2:0]  hsize_q, hsize_d;
  logic [3:0]  hprot_q, hprot_d;

  assign retry_inc  = (retry_cnt == 8'hFF) ? 8'hFF : retry_cnt + 8'd1;
  assign retry_over = (MAX_RETRY != 0) && ({24'd0, retry_inc} > RETRY_LIMIT);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= ST_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    retry_d     = retry_cnt;
    rsp_valid_d = 1'b0;
    rsp_error_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    hbusreq_d   = hbusreq_q;
    hlock_d     = hlock_q;
    htrans_d    = htrans_q;
    haddr_d     = haddr_q;
    hwrite_d    = hwrite_q;
    hsize_d     = hsize_q;
    hprot_d     = hprot_q;
    hwdata_d    = hwdata_q;
    unique case (state)
      ST_IDLE: begin
        if (bus.req_valid) begin
          if (req_illegal(bus.req_size, bus.req_addr[1:0])) begin
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end else begin
            state_d   = ST_ARB;
            retry_d   = 8'd0;
            hbusreq_d = 1'b1;
            hlock_d   = bus.req_lock;
          end
        end
      end
      ST_ARB: begin
        if (bus.hgrant && bus.hready) begin
          state_d  = ST_ADDR;
          htrans_d = HTRANS_NONSEQ;
          haddr_d  = cap_addr;
          hwrite_d = cap_write;
          hsize_d  = cap_size;
          hprot_d  = cap_prot;
        end
      end
      // Once the address phase starts the bus is ours regardless of hgrant.
      ST_ADDR: begin
        if (bus.hready) begin
          state_d   = ST_DATA;
          htrans_d  = HTRANS_IDLE;
          hwdata_d  = cap_wdata;
          hbusreq_d = 1'b0;
        end
      end
      ST_DATA: begin
        if (bus.hready) begin
          state_d     = ST_IDLE;
          hlock_d     = 1'b0;
          rsp_valid_d = 1'b1;
          if (bus.hresp == HRESP_OKAY) begin
            rsp_rdata_d = bus.hrdata;
          end else begin
            rsp_error_d = 1'b1;
          end
        end else if (bus.hresp != HRESP_OKAY) begin
          state_d = ST_RESP2;
        end
      end
      ST_RESP2: begin
        if (bus.hready) begin
          if ((bus.hresp == HRESP_RETRY || bus.hresp == HRESP_SPLIT) && !retry_over) begin
            state_d   = ST_ARB;
            retry_d   = retry_inc;
            hbusreq_d = 1'b1;
          end else begin
            state_d     = ST_IDLE;
            retry_d     = retry_inc;
            hlock_d     = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_error_d = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Request capture happens on every IDLE accept; illegal requests never use it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      retry_cnt   <= 8'd0;
      cap_write   <= 1'b0;
      cap_lock    <= 1'b0;
      cap_addr    <= '0;
      cap_wdata   <= '0;
      cap_size    <= '0;
      cap_prot    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_error_q <= 1'b0;
      rsp_rdata_q <= '0;
      hbusreq_q   <= 1'b0;
      hlock_q     <= 1'b0;
      htrans_q    <= HTRANS_IDLE;
      haddr_q     <= '0;
      hwrite_q    <= 1'b0;
      hsize_q     <= '0;
      hprot_q     <= '0;
      hwdata_q    <= '0;
    end else begin
      retry_cnt <= retry_d;
      if (state == ST_IDLE && bus.req_valid) begin
        cap_write <= bus.req_write;
        cap_lock  <= bus.req_lock;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        cap_size  <= bus.req_size;
        cap_prot  <= bus.req_prot;
      end
      rsp_valid_q <= rsp_valid_d;
      rsp_error_q <= rsp_error_d;
      rsp_rdata_q <= rsp_rdata_d;
      hbusreq_q   <= hbusreq_d;
      hlock_q     <= hlock_d;
      htrans_q    <= htrans_d;
      haddr_q     <= haddr_d;
      hwrite_q    <= hwrite_d;
      hsize_q     <= hsize_d;
      hprot_q     <= hprot_d;
      hwdata_q    <= hwdata_d;
    end
  end

  assign bus.req_ready = (state == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_error = rsp_error_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.hbusreq   = hbusreq_q;
  assign bus.hlock     = hlock_q;
  assign bus.htrans    = htrans_q;
  assign bus.haddr     = haddr_q;
  assign bus.hwrite    = hwrite_q;
  assign bus.hsize     = hsize_q;
  assign bus.hburst    = HBURST_SINGLE;
  assign bus.hprot     = hprot_q;
  assign bus.hwdata    = hwdata_q;

endmodule
